// File: rtl/bsg_clk_lock_sequencer.sv
// MMCM/PLL lock supervisor: pulses the MMCM reset, waits for a stable LOCKED,
// then releases per-domain resets one at a time and recovers from lock loss.
module bsg_clk_lock_sequencer #(
   parameter int num_channels_p        = 2,
   parameter int rst_hold_cycles_p     = 16,
   parameter int lock_timeout_cycles_p = 65536,
   parameter int stable_cycles_p       = 256,
   parameter int stagger_cycles_p      = 8,
   parameter int max_retries_p         = 4,
   parameter int lost_width_p          = 8
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic                               locked_i,
   output logic                               mmcm_rst_o,
   output logic [num_channels_p-1:0]          channel_reset_o,
   output logic                               locked_o,
   output logic                               error_o,
   output logic [lost_width_p-1:0]            lost_count_o,
   output logic [$clog2(max_retries_p+1)-1:0] retry_count_o
);

   localparam int RW   = $clog2(max_retries_p+1);
   localparam int IW   = $clog2(num_channels_p+1);
   localparam int M1   = (rst_hold_cycles_p > lock_timeout_cycles_p) ? rst_hold_cycles_p : lock_timeout_cycles_p;
   localparam int M2   = (stable_cycles_p > stagger_cycles_p) ? stable_cycles_p : stagger_cycles_p;
   localparam int CMAX = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(CMAX+1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(rst_hold_cycles_p-1);
   localparam logic [CW-1:0] TO_LAST   = CW'(lock_timeout_cycles_p-1);
   localparam logic [CW-1:0] STB_LAST  = CW'(stable_cycles_p-1);
   localparam logic [CW-1:0] STG_LAST  = CW'(stagger_cycles_p-1);

   typedef enum logic [2:0] {
      S_HOLD_RST, S_WAIT_LOCK, S_STABILIZE, S_RELEASE, S_RUN, S_FAIL
   } state_t;

   state_t                    r_state, w_state;
   logic [CW-1:0]             r_cnt, w_cnt;
   logic [IW-1:0]             r_idx, w_idx;
   logic [num_channels_p-1:0] r_chan, w_chan;
   logic [RW-1:0]             r_retry, w_retry;
   logic [lost_width_p-1:0]   r_lost, w_lost;
   logic                      r_sync1, r_lock_s;
   logic                      r_mmcm, r_locked, r_err;
   logic                      w_fail, w_loss;

   // LOCKED comes from another clock domain; only r_lock_s is used below.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_sync1  <= 1'b0;
         r_lock_s <= 1'b0;
      end else begin
         r_sync1  <= locked_i;
         r_lock_s <= r_sync1;
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_chan  = r_chan;
      w_retry = r_retry;
      w_lost  = r_lost;
      w_fail  = 1'b0;
      w_loss  = 1'b0;
      case (r_state)
         S_HOLD_RST: begin
            w_chan = '1;
            if (r_cnt == HOLD_LAST) begin
               w_state = S_WAIT_LOCK;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (r_lock_s) begin
               w_state = S_STABILIZE;
               w_cnt   = '0;
            end else if (r_cnt == TO_LAST) begin
               w_fail = 1'b1;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_STABILIZE: begin
            if (!r_lock_s) begin
               w_fail = 1'b1;
            end else if (r_cnt == STB_LAST) begin
               w_state = S_RELEASE;
               w_cnt   = '0;
               w_idx   = '0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_RELEASE: begin
            // Loss is checked first so it beats a same-cycle final release.
            if (!r_lock_s) begin
               w_loss = 1'b1;
            end else if (r_idx == IW'(num_channels_p)) begin
               w_state = S_RUN;
               w_retry = '0;
            end else if (r_cnt == STG_LAST) begin
               w_cnt = '0;
               w_idx = r_idx + IW'(1);
               for (int i = 0; i < num_channels_p; i++)
                  if (r_idx == IW'(i)) w_chan[i] = 1'b0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_RUN: begin
            if (!r_lock_s) w_loss = 1'b1;
         end
         S_FAIL: begin
            w_chan = '1;
         end
         default: begin
            w_state = S_HOLD_RST;
            w_cnt   = '0;
            w_chan  = '1;
         end
      endcase

      if (w_fail) begin
         w_retry = r_retry + RW'(1);
         w_cnt   = '0;
         w_chan  = '1;
         w_state = (w_retry == RW'(max_retries_p)) ? S_FAIL : S_HOLD_RST;
      end
      if (w_loss) begin
         w_chan  = '1;
         w_cnt   = '0;
         w_state = S_HOLD_RST;
         if (r_lost != '1) w_lost = r_lost + lost_width_p'(1);
      end
   end

   // Status outputs are registered from the next state so they never glitch.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= S_HOLD_RST;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_chan   <= '1;
         r_retry  <= '0;
         r_lost   <= '0;
         r_mmcm   <= 1'b1;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_idx    <= w_idx;
         r_chan   <= w_chan;
         r_retry  <= w_retry;
         r_lost   <= w_lost;
         r_mmcm   <= (w_state == S_HOLD_RST) || (w_state == S_FAIL);
         r_locked <= (w_state == S_RUN);
         r_err    <= (w_state == S_FAIL);
      end
   end

   assign mmcm_rst_o      = r_mmcm;
   assign channel_reset_o = r_chan;
   assign locked_o        = r_locked;
   assign error_o         = r_err;
   assign lost_count_o    = r_lost;
   assign retry_count_o   = r_retry;

endmodule

// File: tb/tb_bsg_clk_lock_sequencer.sv
// Bench for bsg_clk_lock_sequencer: phase/age reference model compared every
// cycle, directed scenarios with hand-computed timings, then random lock/reset.
module tb_bsg_clk_lock_sequencer;

   localparam int NCH  = 3;
   localparam int HOLD = 4;
   localparam int TO   = 32;
   localparam int STB  = 8;
   localparam int STG  = 2;
   localparam int MAXR = 2;
   localparam int LW   = 8;
   localparam int RW   = $clog2(MAXR+1);

   logic           clk_i = 1'b0;
   logic           reset_n_i = 1'b0;
   logic           locked_i = 1'b0;
   logic           mmcm_rst_o;
   logic [NCH-1:0] channel_reset_o;
   logic           locked_o;
   logic           error_o;
   logic [LW-1:0]  lost_count_o;
   logic [RW-1:0]  retry_count_o;

   int n_cmp = 0;
   int n_err = 0;
   int n_print = 0;
   bit chk_en = 1'b0;

   bsg_clk_lock_sequencer #(
      .num_channels_p(NCH), .rst_hold_cycles_p(HOLD), .lock_timeout_cycles_p(TO),
      .stable_cycles_p(STB), .stagger_cycles_p(STG), .max_retries_p(MAXR),
      .lost_width_p(LW)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .locked_i(locked_i),
      .mmcm_rst_o(mmcm_rst_o), .channel_reset_o(channel_reset_o),
      .locked_o(locked_o), .error_o(error_o), .lost_count_o(lost_count_o),
      .retry_count_o(retry_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: a phase plus the number of cycles spent in it.
   localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STAB = 2, PH_REL = 3, PH_RUN = 4, PH_FAIL = 5;
   int m_ph, m_age, m_retry, m_lost;
   bit m_s1, m_s2, ls;

   function automatic void m_goto(input int ph);
      m_ph  = ph;
      m_age = 0;
   endfunction

   function automatic void m_fail();
      m_retry++;
      m_goto((m_retry == MAXR) ? PH_FAIL : PH_HOLD);
   endfunction

   function automatic void m_loss();
      if (m_lost < (1 << LW) - 1) m_lost++;
      m_goto(PH_HOLD);
   endfunction

   always @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         m_ph = PH_HOLD; m_age = 0; m_retry = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
      end else begin
         ls   = m_s2;
         m_s2 = m_s1;
         m_s1 = locked_i;
         case (m_ph)
            PH_HOLD: if (m_age == HOLD-1) m_goto(PH_WAIT); else m_age++;
            PH_WAIT: if (ls) m_goto(PH_STAB); else if (m_age == TO-1) m_fail(); else m_age++;
            PH_STAB: if (!ls) m_fail(); else if (m_age == STB-1) m_goto(PH_REL); else m_age++;
            PH_REL: begin
               if (!ls) m_loss();
               else if (m_age == NCH*STG) begin m_goto(PH_RUN); m_retry = 0; end
               else m_age++;
            end
            PH_RUN: if (!ls) m_loss();
            default: ;
         endcase
      end
   end

   always @(negedge clk_i) begin
      logic [NCH-1:0] e_chan;
      logic           e_mmcm, e_lock, e_err;
      if (chk_en) begin
         for (int i = 0; i < NCH; i++)
            e_chan[i] = (m_ph == PH_REL) ? (m_age < (i+1)*STG) : (m_ph != PH_RUN);
         e_mmcm = (m_ph == PH_HOLD) || (m_ph == PH_FAIL);
         e_lock = (m_ph == PH_RUN);
         e_err  = (m_ph == PH_FAIL);
         n_cmp++;
         if (mmcm_rst_o !== e_mmcm || channel_reset_o !== e_chan || locked_o !== e_lock ||
             error_o !== e_err || lost_count_o !== LW'(m_lost) || retry_count_o !== RW'(m_retry)) begin
            n_err++;
            if (n_print < 30) begin
               n_print++;
               $display("FAIL model t=%0t: got rst=%b ch=%b lk=%b err=%b lost=%0d retry=%0d, need rst=%b ch=%b lk=%b err=%b lost=%0d retry=%0d",
                        $time, mmcm_rst_o, channel_reset_o, locked_o, error_o, lost_count_o, retry_count_o,
                        e_mmcm, e_chan, e_lock, e_err, m_lost, m_retry);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h need %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   // Leaves the bench 2 time units after edge 0; the next posedge is edge 1.
   task automatic do_reset(input logic lk);
      reset_n_i = 1'b0;
      locked_i  = lk;
      tick(2);
      reset_n_i = 1'b1;
   endtask

   task automatic wait_locked(input int bound, input string name);
      int k = 0;
      while (!locked_o && k < bound) begin
         tick(1);
         k++;
      end
      check(name, 32'(locked_o), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int seg;
      seg = 0;
      tick(3);
      chk_en = 1'b1;
      check("rst_mmcm", 32'(mmcm_rst_o), 32'd1);
      check("rst_chan", 32'(channel_reset_o), 32'h7);
      check("rst_locked", 32'(locked_o), 32'd0);
      check("rst_err", 32'(error_o), 32'd0);
      check("rst_lost", 32'(lost_count_o), 32'd0);
      check("rst_retry", 32'(retry_count_o), 32'd0);

      // Nominal: lock present from release; release entry at edge 13.
      do_reset(1'b1);
      tick(3);  check("nom_mmcm_hi", 32'(mmcm_rst_o), 32'd1);
      tick(1);  check("nom_mmcm_lo", 32'(mmcm_rst_o), 32'd0);
      tick(10); check("nom_e14_chan", 32'(channel_reset_o), 32'h7);
      tick(1);  check("nom_e15_chan", 32'(channel_reset_o), 32'h6);
      tick(2);  check("nom_e17_chan", 32'(channel_reset_o), 32'h4);
      tick(2);  check("nom_e19_chan", 32'(channel_reset_o), 32'h0);
                check("nom_e19_lock", 32'(locked_o), 32'd0);
      tick(1);  check("nom_e20_lock", 32'(locked_o), 32'd1);

      // One-cycle loss in RUN.
      locked_i = 1'b0; tick(1); locked_i = 1'b1;
      tick(1); check("run_loss_lat", 32'(locked_o), 32'd1);
      tick(1); check("run_loss_chan", 32'(channel_reset_o), 32'h7);
               check("run_loss_lost", 32'(lost_count_o), 32'd1);
               check("run_loss_mmcm", 32'(mmcm_rst_o), 32'd1);
      wait_locked(100, "run_loss_relock");
      check("run_loss_retry", 32'(retry_count_o), 32'd0);

      // Saturating loss counter.
      for (int i = 0; i < 300; i++) begin
         locked_i = 1'b0; tick(1); locked_i = 1'b1; tick(3);
         wait_locked(100, "sat_relock");
      end
      check("sat_lost", 32'(lost_count_o), 32'd255);

      // Two timeouts end in FAIL.
      do_reset(1'b0);
      tick(35); check("to1_pre", 32'(retry_count_o), 32'd0);
      tick(1);  check("to1_retry", 32'(retry_count_o), 32'd1);
                check("to1_mmcm", 32'(mmcm_rst_o), 32'd1);
      tick(35); check("to2_pre", 32'(error_o), 32'd0);
      tick(1);  check("to2_err", 32'(error_o), 32'd1);
                check("to2_retry", 32'(retry_count_o), 32'd2);
      locked_i = 1'b1;
      tick(50); check("fail_sticky", 32'(error_o), 32'd1);
                check("fail_chan", 32'(channel_reset_o), 32'h7);
                check("fail_mmcm", 32'(mmcm_rst_o), 32'd1);

      // Glitchy lock during STABILIZE.
      do_reset(1'b0);
      tick(4); locked_i = 1'b1; tick(5); locked_i = 1'b0;
      tick(4); check("glitch_retry", 32'(retry_count_o), 32'd1);
               check("glitch_chan", 32'(channel_reset_o), 32'h7);
               check("glitch_mmcm", 32'(mmcm_rst_o), 32'd1);
      locked_i = 1'b1;
      wait_locked(100, "glitch_relock");
      check("glitch_retry_clr", 32'(retry_count_o), 32'd0);

      // Loss after channel 0 released.
      do_reset(1'b1);
      tick(13); locked_i = 1'b0;
      tick(2);  check("rel_loss_ch0", 32'(channel_reset_o), 32'h6);
      tick(1);  check("rel_loss_chan", 32'(channel_reset_o), 32'h7);
                check("rel_loss_lost", 32'(lost_count_o), 32'd1);

      // Asynchronous reset between clock edges during RELEASE.
      do_reset(1'b1);
      tick(17); check("arst_pre", 32'(channel_reset_o), 32'h4);
      lost_count_o_probe: begin
         #1 reset_n_i = 1'b0;
         #1;
         check("arst_chan", 32'(channel_reset_o), 32'h7);
         check("arst_mmcm", 32'(mmcm_rst_o), 32'd1);
         check("arst_retry", 32'(retry_count_o), 32'd0);
      end
      tick(1); reset_n_i = 1'b1;

      // Random lock behaviour with occasional resets.
      do_reset(1'b0);
      for (int c = 0; c < 4000; c++) begin
         if (seg == 0) begin
            locked_i = ($urandom_range(0, 3) != 0);
            seg = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : $urandom_range(10, 90);
         end
         seg--;
         if ($urandom_range(0, 299) == 0) begin
            reset_n_i = 1'b0; tick(1); reset_n_i = 1'b1;
         end else begin
            tick(1);
         end
      end

      tick(1);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
